// File: rtl/div_sequencer_if.sv
// Program-ROM / result bus between the division sequencer and its surroundings.
// master: sequencer side (drives selector and results, samples start/func/value).
// slave:  calculator side (drives start and ROM word, samples selector and results).
interface div_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [3:0]       selector;
   logic [2:0]       func;
   logic [3:0]       value;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             disp_valid;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      input  start, func, value,
      output selector, quotient, remainder, disp_valid, busy, done, err
   );

   modport slave (
      output start, func, value,
      input  selector, quotient, remainder, disp_valid, busy, done, err
   );
endinterface

// File: rtl/div_sequencer.sv
// Purpose: program-ROM sequencer for the calculator divider (CLR/LD1/LD2/LD3/DIV/RES/DIS/NOP).
// Latency: FETCH_WAIT+2 cycles per instruction; DIV adds floor(R1/R2)+1 DIVIDE cycles.
// Backpressure: none; start is sampled only in IDLE/HALT and ignored while busy.
// Ports: clk, rst_n (async active-low); bus (master): start, selector, func, value,
//        quotient, remainder, disp_valid, busy, done (HALT-entry pulse), err (sticky).
// Option: define DIV_ZERO_TRAP_EN to halt on divide-by-zero instead of saturating R3.
module div_sequencer #(
   parameter int WIDTH      = 4,
   parameter int PROG_LEN   = 7,
   parameter int FETCH_WAIT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   div_sequencer_if.master bus
);
   localparam int WW = (FETCH_WAIT < 1) ? 1 : $clog2(FETCH_WAIT + 1);

   localparam logic [2:0] OP_CLR = 3'd0;
   localparam logic [2:0] OP_LD1 = 3'd1;
   localparam logic [2:0] OP_LD2 = 3'd2;
   localparam logic [2:0] OP_LD3 = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;
   localparam logic [2:0] OP_RES = 3'd5;
   localparam logic [2:0] OP_DIS = 3'd6;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DIVIDE, S_HALT} state_t;

   state_t           state, state_nxt;
   logic [WW-1:0]    wcnt, wcnt_nxt;
   logic [3:0]       sel, sel_nxt;
   logic [2:0]       ir_func, ir_func_nxt;
   logic [3:0]       ir_val, ir_val_nxt;
   logic [WIDTH-1:0] r1, r1_nxt, r2, r2_nxt, r3, r3_nxt;
   logic [WIDTH-1:0] res_q, res_q_nxt, res_r, res_r_nxt;
   logic [WIDTH-1:0] quo, quo_nxt, rem, rem_nxt;
   logic             dvld, dvld_nxt, done_q, done_nxt, err_q, err_nxt;
   logic             advance;
   logic [4:0]       sel_inc;
   logic [WIDTH-1:0] imm;

   assign sel_inc = {1'b0, sel} + 5'd1;
   assign imm     = WIDTH'(ir_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         sel     <= '0;
         ir_func <= '0;
         ir_val  <= '0;
         r1      <= '0;
         r2      <= '0;
         r3      <= '0;
         res_q   <= '0;
         res_r   <= '0;
         quo     <= '0;
         rem     <= '0;
         dvld    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         wcnt    <= wcnt_nxt;
         sel     <= sel_nxt;
         ir_func <= ir_func_nxt;
         ir_val  <= ir_val_nxt;
         r1      <= r1_nxt;
         r2      <= r2_nxt;
         r3      <= r3_nxt;
         res_q   <= res_q_nxt;
         res_r   <= res_r_nxt;
         quo     <= quo_nxt;
         rem     <= rem_nxt;
         dvld    <= dvld_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wcnt_nxt    = wcnt;
      sel_nxt     = sel;
      ir_func_nxt = ir_func;
      ir_val_nxt  = ir_val;
      r1_nxt      = r1;
      r2_nxt      = r2;
      r3_nxt      = r3;
      res_q_nxt   = res_q;
      res_r_nxt   = res_r;
      quo_nxt     = quo;
      rem_nxt     = rem;
      dvld_nxt    = dvld;
      done_nxt    = 1'b0;
      err_nxt     = err_q;
      advance     = 1'b0;

      case (state)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               state_nxt = S_FETCH;
               sel_nxt   = '0;
               wcnt_nxt  = '0;
               err_nxt   = 1'b0;
            end
         end
         S_FETCH: begin
            // ROM output is only trusted once FETCH_WAIT cycles have elapsed
            if (wcnt == WW'(FETCH_WAIT)) begin
               ir_func_nxt = bus.func;
               ir_val_nxt  = bus.value;
               state_nxt   = S_EXEC;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         S_EXEC: begin
            case (ir_func)
               OP_CLR: begin
                  r1_nxt    = '0;
                  r2_nxt    = '0;
                  r3_nxt    = '0;
                  res_q_nxt = '0;
                  res_r_nxt = '0;
                  dvld_nxt  = 1'b0;
                  advance   = 1'b1;
               end
               OP_LD1: begin r1_nxt = imm; advance = 1'b1; end
               OP_LD2: begin r2_nxt = imm; advance = 1'b1; end
               OP_LD3: begin r3_nxt = imm; advance = 1'b1; end
               OP_DIV: begin
                  if (r2 == '0) begin
                     err_nxt = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                     state_nxt = S_HALT;
                     done_nxt  = 1'b1;
`else
                     // saturate the quotient and let the program carry on
                     r3_nxt  = '1;
                     advance = 1'b1;
`endif
                  end else begin
                     state_nxt = S_DIVIDE;
                  end
               end
               OP_RES: begin
                  res_q_nxt = r3;
                  res_r_nxt = r1;
                  advance   = 1'b1;
               end
               OP_DIS: begin
                  quo_nxt   = res_q;
                  rem_nxt   = res_r;
                  dvld_nxt  = 1'b1;
                  state_nxt = S_HALT;
                  done_nxt  = 1'b1;
               end
               default: advance = 1'b1;
            endcase
         end
         S_DIVIDE: begin
            if (r1 >= r2) begin
               r1_nxt = r1 - r2;
               r3_nxt = r3 + 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Falling off the end of the program without DIS is an overrun;
      // selector is left on the last word so the offending address is visible.
      if (advance) begin
         if (sel_inc == 5'(PROG_LEN)) begin
            err_nxt   = 1'b1;
            state_nxt = S_HALT;
            done_nxt  = 1'b1;
         end else begin
            sel_nxt   = sel_inc[3:0];
            wcnt_nxt  = '0;
            state_nxt = S_FETCH;
         end
      end
   end

   assign bus.selector   = sel;
   assign bus.quotient   = quo;
   assign bus.remainder  = rem;
   assign bus.disp_valid = dvld;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_DIVIDE);
endmodule
